// File: rtl/pio_pkg.sv
// Shared definitions for the Avalon-MM GPIO slave: register word addresses
// and the edge-capture selection encoding.
package pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain, previous-value register and warm-up gate that
// together produce the per-bit edge events for the GPIO edge-capture register.
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int WIDTH       = 27,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] ev
);

    localparam logic [2:0] WARM_CYCLES = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] chain [SYNC_STAGES];
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] sel;
    logic [2:0]       warm_cnt;
    logic             warm_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign sync_in = chain[SYNC_STAGES-1];

    // prev follows sync_in every cycle, so a direction turnaround never sees a stale value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= sync_in;
        end
    end

    // Suppresses events until the chain has flushed the reset zeros
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt <= '0;
        end else if (!warm_done) begin
            warm_cnt <= warm_cnt + 3'd1;
        end
    end

    assign warm_done = (warm_cnt == WARM_CYCLES);
    assign rise      = sync_in & ~prev;
    assign fall      = ~sync_in & prev;

    always_comb begin
        sel = rise;
        if (EDGE_TYPE == int'(EDGE_FALL)) begin
            sel = fall;
        end else if (EDGE_TYPE == int'(EDGE_ANY)) begin
            sel = rise | fall;
        end
    end

    assign ev = warm_done ? sel : '0;

endmodule

// File: rtl/avalon_pio_gpio.sv
// Avalon-MM GPIO slave: data/direction registers, atomic set/clear,
// maskable edge capture with a registered level interrupt.
module avalon_pio_gpio
    import pio_pkg::*;
#(
    parameter int               WIDTH       = 27,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] rd_word;

    assign wr = chipselect && !write_n;
    assign wd = writedata[WIDTH-1:0];

    if (WIDTH < 32) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^writedata[31:WIDTH];
    end

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .sync_in (sync_in),
        .ev      (ev)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
        end else if (wr) begin
            case (address)
                ADDR_DATA:   data_out <= wd;
                ADDR_OUTSET: data_out <= data_out | wd;
                ADDR_OUTCLR: data_out <= data_out & ~wd;
                default:     data_out <= data_out;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir     <= DIR_RESET;
            irqmask <= '0;
        end else if (wr) begin
            if (address == ADDR_DIR) begin
                dir <= wd;
            end
            if (address == ADDR_IRQMASK) begin
                irqmask <= wd;
            end
        end
    end

    // A new event wins over a same-cycle write-1-to-clear; output bits never capture
    assign clr_mask = (wr && address == ADDR_EDGECAP) ? wd : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
            irq     <= 1'b0;
        end else begin
            edgecap <= (edgecap & ~clr_mask) | (ev & ~dir);
            irq     <= |(edgecap & irqmask);
        end
    end

    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA:    rd_word = (dir & data_out) | (~dir & sync_in);
            ADDR_DIR:     rd_word = dir;
            ADDR_IRQMASK: rd_word = irqmask;
            ADDR_EDGECAP: rd_word = edgecap;
            default:      rd_word = '0;
        endcase
    end

    always_comb begin
        readdata = '0;
        readdata[WIDTH-1:0] = rd_word;
    end

    assign out_port = data_out;
    assign oe       = dir;

endmodule

// File: tb/tb_avalon_pio_gpio.sv
// Directed bench for avalon_pio_gpio: one instance with preset reset values and
// rising-edge capture, a second with default reset values and any-edge capture.
module tb_avalon_pio_gpio;

    localparam int W = 27;

    logic          clk;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          chipselect2;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [31:0]   readdata2;
    logic [W-1:0]  in_port;
    logic [W-1:0]  in_port2;
    logic [W-1:0]  out_port;
    logic [W-1:0]  out_port2;
    logic [W-1:0]  oe;
    logic [W-1:0]  oe2;
    logic          irq;
    logic          irq2;

    int vectors;
    int miscompares;

    avalon_pio_gpio #(
        .WIDTH       (W),
        .RESET_VALUE (27'h00005A5),
        .DIR_RESET   (27'h7FFFFFF),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe         (oe),
        .irq        (irq)
    );

    avalon_pio_gpio #(
        .WIDTH       (W),
        .RESET_VALUE (27'h0),
        .DIR_RESET   (27'h0),
        .EDGE_TYPE   (2),
        .SYNC_STAGES (2)
    ) dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect2),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata2),
        .in_port    (in_port2),
        .out_port   (out_port2),
        .oe         (oe2),
        .irq        (irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic readRegister(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    logic [31:0] rd;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        address     = 3'd0;
        chipselect  = 1'b0;
        chipselect2 = 1'b0;
        write_n     = 1'b1;
        writedata   = 32'h0;
        in_port     = '0;
        in_port2    = '1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Reset values
        checkOutput("rst_out_port", 32'(out_port), 32'h000005A5);
        checkOutput("rst_oe", 32'(oe), 32'h07FFFFFF);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        readRegister(3'd0, rd);
        checkOutput("rst_data_read", rd, 32'h000005A5);

        // Pins held high through reset release must not be captured
        address = 3'd3;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (i % 10 == 9) checkOutput("warmup_edgecap", readdata2, 32'h0);
        end
        checkOutput("warmup_irq", 32'(irq2), 32'h0);

        @(negedge clk);
        in_port2[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("any_edge_fall", readdata2, 32'h00000002);

        // Set/clear
        applyStimulus(3'd0, 32'h000000F0);
        applyStimulus(3'd4, 32'h0000000F);
        checkOutput("outset_port", 32'(out_port), 32'h000000FF);
        applyStimulus(3'd5, 32'h00000030);
        checkOutput("outclr_port", 32'(out_port), 32'h000000CF);
        readRegister(3'd0, rd);
        checkOutput("setclr_data_read", rd, 32'h000000CF);
        readRegister(3'd4, rd);
        checkOutput("outset_read", rd, 32'h0);
        readRegister(3'd5, rd);
        checkOutput("outclr_read", rd, 32'h0);

        // Edge capture and irq latency
        applyStimulus(3'd1, 32'h0);
        applyStimulus(3'd2, 32'h1);
        readRegister(3'd3, rd);
        checkOutput("edgecap_idle", rd, 32'h0);
        @(negedge clk);
        in_port[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        readRegister(3'd3, rd);
        checkOutput("edgecap_latency", rd, 32'h1);
        checkOutput("irq_not_yet", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("irq_set", 32'(irq), 32'h1);
        applyStimulus(3'd3, 32'h1);
        readRegister(3'd3, rd);
        checkOutput("w1c_cleared", rd, 32'h0);
        checkOutput("irq_lag", 32'(irq), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("irq_cleared", 32'(irq), 32'h0);

        // Set beats same-cycle clear
        @(negedge clk);
        in_port[0] = 1'b0;
        repeat (5) @(negedge clk);
        readRegister(3'd3, rd);
        checkOutput("fall_ignored", rd, 32'h0);
        in_port[0] = 1'b1;
        @(negedge clk);
        applyStimulus(3'd3, 32'h1);
        readRegister(3'd3, rd);
        checkOutput("collision_set_wins", rd, 32'h1);
        applyStimulus(3'd3, 32'h1);
        readRegister(3'd3, rd);
        checkOutput("collision_after_clr", rd, 32'h0);

        // Direction turnaround
        applyStimulus(3'd1, 32'h8);
        applyStimulus(3'd0, 32'h8);
        checkOutput("dir_oe", 32'(oe), 32'h00000008);
        checkOutput("dir_out_port", 32'(out_port), 32'h00000008);
        in_port[3] = 1'b1;
        repeat (5) @(negedge clk);
        in_port[3] = 1'b0;
        repeat (5) @(negedge clk);
        readRegister(3'd3, rd);
        checkOutput("output_no_capture", rd, 32'h0);
        applyStimulus(3'd1, 32'h0);
        repeat (5) @(negedge clk);
        readRegister(3'd3, rd);
        checkOutput("turnaround_no_capture", rd, 32'h0);
        readRegister(3'd0, rd);
        checkOutput("input_data_read", rd, 32'h00000001);
        in_port[3] = 1'b1;
        repeat (5) @(negedge clk);
        readRegister(3'd3, rd);
        checkOutput("input_capture", rd, 32'h00000008);

        applyStimulus(3'd2, 32'h8);
        checkOutput("mask_irq_lag", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("mask_irq_set", 32'(irq), 32'h1);

        // Width rule
        applyStimulus(3'd1, 32'hFFFFFFFF);
        applyStimulus(3'd0, 32'hFFFFFFFF);
        readRegister(3'd0, rd);
        checkOutput("width_data_read", rd, 32'h07FFFFFF);
        readRegister(3'd1, rd);
        checkOutput("width_dir_read", rd, 32'h07FFFFFF);
        checkOutput("width_out_port", 32'(out_port), 32'h07FFFFFF);

        // Reset mid-operation
        checkOutput("pre_reset_irq", 32'(irq), 32'h1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_irq", 32'(irq), 32'h0);
        checkOutput("midrst_out_port", 32'(out_port), 32'h000005A5);
        checkOutput("midrst_oe", 32'(oe), 32'h07FFFFFF);
        readRegister(3'd3, rd);
        checkOutput("midrst_edgecap", rd, 32'h0);
        readRegister(3'd2, rd);
        checkOutput("midrst_irqmask", rd, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
